// File: rtl/fp16_operand_unpacker.sv
// Unpacks an fp16 operand into sign / unbiased exponent / normalized significand plus class flags.
// Define FP16_UNPACK_FAST_NORM_EN to normalize subnormals in the accept cycle instead of iteratively.
module fp16_operand_unpacker #(
  parameter int EXP_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [10:0]      significand,
  output logic             is_zero,
  output logic             is_subnormal,
  output logic             is_inf,
  output logic             is_nan,
  output logic             is_snan,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // out_valid stays high with outputs frozen until out_ready is seen.
  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [EXP_W-1:0] BIAS    = EXP_W'(15);
  localparam logic [EXP_W-1:0] SUB_EXP = EXP_W'(-14);

  state_t           state, state_n;
  logic             sign_n;
  logic [EXP_W-1:0] exp_n;
  logic [10:0]      sig_n;
  logic [4:0]       flags_n;
  logic             accept;
  logic [4:0]       x_exp;
  logic [9:0]       x_frac;

`ifdef FP16_UNPACK_FAST_NORM_EN
  logic [3:0] lz;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  assign lz = lzc11({1'b0, x_frac});
`endif

  assign x_exp     = x[14:10];
  assign x_frac    = x[9:0];
  assign out_valid = (state == DONE);
  assign state_dbg = state;
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_n = state;
    sign_n  = sign;
    exp_n   = exponent;
    sig_n   = significand;
    flags_n = {is_zero, is_subnormal, is_inf, is_nan, is_snan};
    case (state)
      NORM: begin
        sig_n = {significand[9:0], 1'b0};
        exp_n = exponent - EXP_W'(1);
        if (sig_n[10]) state_n = DONE;
      end
      DONE: if (out_ready && !in_valid) state_n = IDLE;
      default: ;
    endcase
    if (accept) begin
      sign_n  = x[15];
      flags_n = 5'b0;
      state_n = DONE;
      if (x_exp == 5'd0 && x_frac == 10'd0) begin
        flags_n[4] = 1'b1;
        exp_n      = '0;
        sig_n      = '0;
      end else if (x_exp == 5'd31 && x_frac == 10'd0) begin
        flags_n[2] = 1'b1;
        exp_n      = '0;
        sig_n      = '0;
      end else if (x_exp == 5'd31) begin
        flags_n[1] = 1'b1;
        flags_n[0] = ~x_frac[9];
        exp_n      = '0;
        sig_n      = {1'b1, x_frac};
      end else if (x_exp != 5'd0) begin
        exp_n = EXP_W'(x_exp) - BIAS;
        sig_n = {1'b1, x_frac};
      end else begin
        flags_n[3] = 1'b1;
`ifdef FP16_UNPACK_FAST_NORM_EN
        sig_n = {1'b0, x_frac} << lz;
        exp_n = SUB_EXP - EXP_W'(lz);
`else
        sig_n   = {1'b0, x_frac};
        exp_n   = SUB_EXP;
        state_n = NORM;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sign         <= 1'b0;
      exponent     <= '0;
      significand  <= '0;
      is_zero      <= 1'b0;
      is_subnormal <= 1'b0;
      is_inf       <= 1'b0;
      is_nan       <= 1'b0;
      is_snan      <= 1'b0;
    end else begin
      state        <= state_n;
      sign         <= sign_n;
      exponent     <= exp_n;
      significand  <= sig_n;
      is_zero      <= flags_n[4];
      is_subnormal <= flags_n[3];
      is_inf       <= flags_n[2];
      is_nan       <= flags_n[1];
      is_snan      <= flags_n[0];
    end
  end

endmodule

// File: tb/tb_fp16_operand_unpacker.sv
// Directed bench for fp16_operand_unpacker: classification, subnormal latency, back-pressure, reset abort.
module tb_fp16_operand_unpacker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x;
  logic        sign, is_zero, is_subnormal, is_inf, is_nan, is_snan;
  logic [6:0]  exponent;
  logic [10:0] significand;
  logic [1:0]  state_dbg;

  int tests = 0;
  int failed = 0;

  fp16_operand_unpacker #(.EXP_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exponent(exponent),
    .significand(significand), .is_zero(is_zero), .is_subnormal(is_subnormal),
    .is_inf(is_inf), .is_nan(is_nan), .is_snan(is_snan), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags = {is_zero, is_subnormal, is_inf, is_nan, is_snan}
  task automatic check_out(input string tag, input logic s, input logic [6:0] e,
                           input logic [10:0] sg, input logic [4:0] fl);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sign"}, 32'(sign), 32'(s));
    check({tag, ".exp"}, 32'(exponent), 32'(e));
    check({tag, ".sig"}, 32'(significand), 32'(sg));
    check({tag, ".flags"}, 32'({is_zero, is_subnormal, is_inf, is_nan, is_snan}), 32'(fl));
  endtask

  task automatic send(input string tag, input logic [15:0] v);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Offer a competing operand while waiting; it must never be taken.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    in_valid = 1'b1;
    x = 16'h3C00;
    while (!out_valid && lat < 40) begin
      check({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic unpack(input string tag, input logic [15:0] v, input int sub_lat,
                        input logic s, input logic [6:0] e, input logic [10:0] sg,
                        input logic [4:0] fl);
    send(tag, v);
`ifdef FP16_UNPACK_FAST_NORM_EN
    wait_valid(tag, 0);
`else
    wait_valid(tag, sub_lat);
`endif
    check_out(tag, s, e, sg, fl);
    consume(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 16'h0;
    tick();
    tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.outs", 32'({sign, exponent, significand}), 32'd0);
    check("rst.flags", 32'({is_zero, is_subnormal, is_inf, is_nan, is_snan}), 32'd0);
    check("rst.state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);

    unpack("one",    16'h3C00, 0,  1'b0, 7'h00, 11'h400, 5'b00000);
    unpack("minsub", 16'h0001, 10, 1'b0, 7'h68, 11'h400, 5'b01000);
    unpack("maxsub", 16'h0200, 1,  1'b0, 7'h71, 11'h400, 5'b01000);
    unpack("sub3ff", 16'h83FF, 1,  1'b1, 7'h71, 11'h7FE, 5'b01000);
    unpack("snan",   16'h7D00, 0,  1'b0, 7'h00, 11'h500, 5'b00011);
    unpack("qnan",   16'h7E00, 0,  1'b0, 7'h00, 11'h600, 5'b00010);
    unpack("ninf",   16'hFC00, 0,  1'b1, 7'h00, 11'h000, 5'b00100);
    unpack("nzero",  16'h8000, 0,  1'b1, 7'h00, 11'h000, 5'b10000);
    unpack("maxnrm", 16'h7BFF, 0,  1'b0, 7'h0F, 11'h7FF, 5'b00000);
    unpack("minnrm", 16'h0400, 0,  1'b0, 7'h72, 11'h400, 5'b00000);

    // Back-pressure then back-to-back accept.
    send("two", 16'h4000);
    check_out("two", 1'b0, 7'h01, 11'h400, 5'b00000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("two_hold", 1'b0, 7'h01, 11'h400, 5'b00000);
      check("two_hold.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 16'hC500;
    #1;
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_out("b2b", 1'b1, 7'h02, 11'h500, 5'b00000);
    consume("b2b");

    // Reset during normalization discards the partial result.
    send("abort", 16'h0003);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("abort.valid", 32'(out_valid), 32'd0);
    check("abort.outs", 32'({sign, exponent, significand}), 32'd0);
    check("abort.flags", 32'({is_zero, is_subnormal, is_inf, is_nan, is_snan}), 32'd0);
    check("abort.state", 32'(state_dbg), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort.in_ready", 32'(in_ready), 32'd1);
    unpack("after", 16'h3C00, 0, 1'b0, 7'h00, 11'h400, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fp16_operand_unpacker.md
Name: fp16_operand_unpacker

Overview:
- Front end of the fma16 datapath: accepts a packed IEEE-754 half-precision operand over a valid/ready handshake.
- Splits it into sign, unbiased exponent and an 11-bit significand with the explicit leading one, and classifies it.
- Subnormal inputs are normalized iteratively, one left shift per cycle, so downstream multiply/add/rounding logic always sees a normalized significand plus special-case flags.

Parameters:
- EXP_W, 7, width of the signed unbiased exponent output (two's complement; must cover -24..+15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand present
- in_ready  out  1  unpacker can accept an operand
- x  in  16  packed fp16 operand {sign, exp[4:0], frac[9:0]}
- out_valid  out  1  unpacked result valid
- out_ready  in  1  consumer accepts the result
- sign  out  1  operand sign
- exponent  out  EXP_W  signed unbiased exponent
- significand  out  11  normalized significand, bit 10 = leading one
- is_zero  out  1  operand is +/-0
- is_subnormal  out  1  operand was subnormal
- is_inf  out  1  operand is +/-infinity
- is_nan  out  1  operand is NaN (quiet or signaling)
- is_snan  out  1  operand is a signaling NaN (frac[9]=0, frac!=0)

Behaviour:
- Reset (async, reset_n=0): state IDLE; out_valid=0; all result outputs and flags 0; in_ready=1 once reset_n=1.
- States: IDLE, NORM, DONE.
- in_ready=1 in IDLE, and in DONE when out_ready=1 (back-to-back). in_ready=0 in NORM.
- Accept: in_valid & in_ready at a clock edge registers sign=x[15] and classifies the operand.
- exp=0, frac=0: is_zero=1, exponent=0, significand=0 -> DONE.
- exp=31, frac=0: is_inf=1, significand=0 -> DONE.
- exp=31, frac!=0: is_nan=1, is_snan=~frac[9], significand={1'b1, frac} -> DONE.
- Normal: exponent=exp-15, significand={1'b1, frac} -> DONE.
- exp=0, frac!=0: is_subnormal=1, exponent=-14, significand={1'b0, frac} -> NORM.
- NORM, each cycle: while significand[10]=0, shift significand left 1 and decrement exponent. Go to DONE on the cycle the shifted value has bit 10 set.
- Latency after the accept edge: 1 cycle for non-subnormals; 1+k cycles for subnormals, where k = leading zeros of {0, frac} within 11 bits (1..10). 0x0001 -> k=10, exponent=-24.
- DONE: out_valid=1. All outputs held stable until out_ready=1.
- Handshake in DONE:
  - out_ready=1 and in_valid=1 -> new operand accepted in the same cycle; next state per classification; out_valid stays 1 only if the new operand goes directly to DONE.
  - out_ready=1 and in_valid=0 -> IDLE; out_valid=0.
- out_valid is never asserted in IDLE or NORM.
- in_valid while in NORM is ignored and not captured.
- reset_n low in any state, including mid-NORM, aborts immediately to reset values; the partial result is discarded.
- Exponent arithmetic is EXP_W-bit two's complement; no saturation is needed in range.

Optional Feature:
- Macro: FP16_UNPACK_FAST_NORM_EN.
- Defined: a combinational 11-bit leading-zero counter normalizes subnormals in the accept cycle. NORM is never entered and every operand has 1-cycle latency. Outputs are identical to the iterative mode.
- Undefined: iterative NORM behaviour as above.

Test Plan:
- x=0x3C00 accepted -> next cycle out_valid=1, sign=0, exponent=0, significand=0x400, all flags 0.
- x=0x0001 -> 10 NORM cycles; out_valid on cycle 11 after accept; exponent=-24 (7'h68), significand=0x400, is_subnormal=1. With FAST_NORM_EN: same values after 1 cycle.
- x=0x7D00 -> is_nan=1, is_snan=1. x=0x7E00 -> is_nan=1, is_snan=0. x=0xFC00 -> sign=1, is_inf=1. x=0x8000 -> sign=1, is_zero=1.
- 0x4000 accepted, out_ready held 0 for 5 cycles -> outputs stable (exponent=1, significand=0x400) and in_ready=0. On out_ready=1 with in_valid=1 and x=0xC500, the second operand is accepted the same cycle -> next output sign=1, exponent=2, significand=0x500.
- x=0x0003 accepted, reset_n pulsed low on the 3rd NORM cycle -> out_valid=0 and outputs 0 immediately; in_ready=1 after release; a following 0x3C00 is unpacked correctly.
